// File: rtl/nios_buttons_pkg.sv
// rtl/nios_buttons_pkg.sv - shared register map and edge-select codes for the button controller
package nios_buttons_pkg;

  localparam logic [1:0] ADDR_LEVEL = 2'd0;
  localparam logic [1:0] ADDR_SYNC  = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;
  localparam logic [1:0] ADDR_EDGE  = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/nios_button_debounce.sv
// rtl/nios_button_debounce.sv - one button bit: 2-flop synchroniser, stability counter, debounced level
module nios_button_debounce #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic sync_o,
  output logic level_o,
  output logic level_next_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q;
  logic          sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synced input disagrees with the accepted level,
  // so a single matching sample restarts the stability window.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= RESET_LEVEL;
      sync_q  <= RESET_LEVEL;
      level_q <= RESET_LEVEL;
      cnt_q   <= '0;
    end else begin
      meta_q  <= pin_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sync_o       = sync_q;
  assign level_o      = level_q;
  assign level_next_o = level_d;

endmodule

// File: rtl/nios_buttons_ctrl.sv
// rtl/nios_buttons_ctrl.sv - Avalon-MM button bank: debounce, sticky edge capture, maskable irq
module nios_buttons_ctrl
  import nios_buttons_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = WIDTH'(4'hF)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_w, level_w, level_next_w;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nios_button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL[i])
    ) u_debounce (
      .clk         (clk),
      .rst_n       (reset_n),
      .pin_i       (in_port[i]),
      .sync_o      (sync_w[i]),
      .level_o     (level_w[i]),
      .level_next_o(level_next_w[i])
    );
  end

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata[31:WIDTH];

  // Edges are taken from the level about to be latched so capture lands on the toggle edge.
  always_comb begin
    case (EDGE_TYPE)
      EDGE_RISING:  edge_det = ~level_w & level_next_w;
      EDGE_FALLING: edge_det = level_w & ~level_next_w;
      default:      edge_det = level_w ^ level_next_w;
    endcase
  end

  always_comb begin
    irq_mask_d = irq_mask_q;
    edgecap_d  = edgecap_q;
    if (wr_en && address == ADDR_MASK) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && address == ADDR_EDGE) begin
      edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
    end
    edgecap_d = edgecap_d | edge_det;
    irq_d     = |(edgecap_q & irq_mask_q);
    case (address)
      ADDR_LEVEL: readdata_d = 32'(level_w);
      ADDR_SYNC:  readdata_d = 32'(sync_w);
      ADDR_MASK:  readdata_d = 32'(irq_mask_q);
      default:    readdata_d = 32'(edgecap_q);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_q <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_nios_buttons_ctrl.sv
// tb/tb_nios_buttons_ctrl.sv - scoreboard bench for nios_buttons_ctrl
module tb_nios_buttons_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  typedef struct {
    logic [31:0] value;
    string       name;
  } exp_t;

  exp_t rd_q[$];
  exp_t irq_q[$];
  logic rd_req  = 1'b0;
  logic irq_req = 1'b0;
  int   passed  = 0;
  int   total   = 0;

  nios_buttons_ctrl #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE      (1),
    .RESET_LEVEL    (4'hF)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    logic do_rd, do_irq;
    exp_t e;
    do_rd  = rd_req;
    do_irq = irq_req;
    #1;
    if (do_rd) begin
      total++;
      if (rd_q.size() == 0) begin
        $display("FAIL read_underflow: readdata=%h, no expected value queued", readdata);
      end else begin
        e = rd_q.pop_front();
        if (readdata === e.value) passed++;
        else $display("FAIL %s: readdata=%h expected=%h", e.name, readdata, e.value);
      end
    end
    if (do_irq) begin
      total++;
      if (irq_q.size() == 0) begin
        $display("FAIL irq_underflow: irq=%b, no expected value queued", irq);
      end else begin
        e = irq_q.pop_front();
        if (irq === e.value[0]) passed++;
        else $display("FAIL %s: irq=%b expected=%b", e.name, irq, e.value[0]);
      end
    end
  end

  task automatic rd(input logic [1:0] a, input logic [31:0] v, input string n);
    exp_t e;
    e.value = v;
    e.name  = n;
    address = a;
    rd_q.push_back(e);
    rd_req = 1'b1;
  endtask

  task automatic chk_irq(input logic v, input string n);
    exp_t e;
    e.value = {31'd0, v};
    e.name  = n;
    irq_q.push_back(e);
    irq_req = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        rd_req     = 1'b0;
        irq_req    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
      end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;
    @(negedge clk);
    rd(2'd0, 32'h0, "reset_readdata");
    chk_irq(1'b0, "reset_irq");
    tick(2);
    reset_n = 1'b1;
    rd(2'd0, 32'hF, "reset_level");
    tick(1);
    rd(2'd3, 32'h0, "reset_edgecap");
    tick(3);

    // clean press of bit0: level changes exactly 6 clocks after the pin
    in_port = 4'hE;
    tick(5);
    rd(2'd0, 32'hF, "press_level_before");
    tick(1);
    rd(2'd0, 32'hE, "press_level_after");
    tick(1);
    rd(2'd3, 32'h1, "press_edgecap");
    tick(1);
    wr(2'd3, 32'h1);
    tick(1);
    rd(2'd3, 32'h0, "w1c_edgecap");
    tick(1);

    // release: rising edge is not captured with falling-edge selection
    in_port = 4'hF;
    tick(6);
    rd(2'd0, 32'hF, "release_level");
    tick(1);
    rd(2'd3, 32'h0, "release_no_edge");
    tick(1);

    // bounce: three low clocks never reach the terminal count
    for (int k = 0; k < 3; k++) begin
      in_port = 4'hE;
      tick(3);
      in_port = 4'hF;
      rd(2'd1, 32'hE, "bounce_sync");
      tick(2);
    end
    tick(4);
    rd(2'd0, 32'hF, "bounce_level");
    tick(1);
    rd(2'd3, 32'h0, "bounce_edgecap");
    tick(1);

    // irq path
    wr(2'd2, 32'h1);
    tick(1);
    in_port = 4'hE;
    tick(5);
    chk_irq(1'b0, "irq_before_edge");
    tick(1);
    chk_irq(1'b1, "irq_after_edge");
    rd(2'd3, 32'h1, "irq_edgecap");
    tick(1);
    wr(2'd3, 32'h1);
    chk_irq(1'b1, "irq_held_during_w1c");
    tick(1);
    chk_irq(1'b0, "irq_cleared");
    tick(1);
    in_port = 4'hC;
    tick(7);
    chk_irq(1'b0, "irq_masked_bit1");
    rd(2'd3, 32'h2, "masked_edgecap");
    tick(1);
    wr(2'd3, 32'h2);
    tick(1);

    // collision: W1C of bit2 lands on the same edge bit2 falls
    in_port = 4'h8;
    tick(5);
    wr(2'd3, 32'h4);
    tick(1);
    rd(2'd3, 32'h4, "collision_set_wins");
    tick(1);
    rd(2'd2, 32'h1, "mask_readback");
    tick(1);
    in_port = 4'hF;
    tick(7);
    rd(2'd0, 32'hF, "release_all_level");
    tick(1);
    rd(2'd3, 32'h4, "release_all_edgecap");
    tick(1);

    // reset mid-run with irq high and a press mid-debounce
    wr(2'd2, 32'h4);
    tick(2);
    chk_irq(1'b1, "irq_before_reset");
    tick(1);
    in_port = 4'hE;
    tick(3);
    reset_n = 1'b0;
    rd(2'd3, 32'h0, "midrun_reset_readdata");
    chk_irq(1'b0, "midrun_reset_irq");
    tick(2);
    reset_n = 1'b1;
    rd(2'd0, 32'hF, "post_reset_level");
    tick(1);
    rd(2'd3, 32'h0, "post_reset_edgecap");
    chk_irq(1'b0, "post_reset_irq");
    tick(1);
    rd(2'd2, 32'h0, "post_reset_mask");
    tick(1);
    in_port = 4'hF;
    tick(4);

    if (rd_q.size() != 0 || irq_q.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: rd left=%0d irq left=%0d required=0", rd_q.size(), irq_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
